// File: rtl/mc_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_pkg
//  Description : Shared definitions for the multi-cycle MIPS sequencer:
//                opcode constants, FSM state encodings, and the datapath
//                select codes driven onto alu_src_b, alu_op and pc_source.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_control_pkg;

    // Opcode field, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Sequencer states; encodings are visible on the debug state port
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_e;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // ALU operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Next-pc source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on the unified memory through mem_ready
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_mem_wait_timer
//  Description : Watchdog for memory states. Counts consecutive cycles in
//                which the memory has not responded; flags expiry once the
//                count has reached LIMIT.
//  Ports       : clk, rst        clock / async active-high reset
//                clr_i           restart count (state entry)
//                en_i            count one more stalled cycle
//                expired_o       count already equals LIMIT
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control_mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int TW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign expired_o = (count_q == TW'(LIMIT));

    // Saturate at LIMIT; the sequencer aborts (and clears) before it matters
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle sequencer for the MIPS datapath. Steps each
//                instruction through fetch/decode/execute/memory/writeback,
//                decodes datapath selects from the current state, handles a
//                variable-latency memory via mem_ready with a watchdog, and
//                counts retired instructions.
//  Ports       : clk, rst              clock / async active-high reset
//                op_i, zero_i          opcode field, ALU zero flag
//                mem_ready_i           memory completed the current access
//                pc_en_o .. pc_source_o datapath selects and enables
//                state_o               current state (debug)
//                instr_done_o          retire pulse
//                illegal_op_o          unsupported-opcode pulse
//                mem_timeout_o         sticky watchdog flag
//                instr_count_o         retired instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_en_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             reg_write_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic [1:0]       pc_source_o,
    output logic [3:0]       state_o,
    output logic             instr_done_o,
    output logic             illegal_op_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_e           state_q;
    state_e           state_d;
    logic             instr_done_q;
    logic             illegal_op_q;
    logic             mem_timeout_q;
    logic [CNT_W-1:0] instr_count_q;

    logic             w_expired;
    logic             w_abort;
    logic             w_retire;
    logic             w_illegal;
    logic             w_timer_clr;
    logic             w_timer_en;
    logic             w_pc_write;
    logic             w_pc_write_cond;

    // ------------------------------------------------------------------
    // Watchdog: restarts on every state change (and on an abort, since an
    // aborted fetch re-enters FETCH without a visible state change).
    // ------------------------------------------------------------------
    assign w_timer_en  = is_mem_state(state_q) && !mem_ready_i;
    assign w_timer_clr = (state_d != state_q) || w_abort;

    mc_control_mem_wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_timer_clr),
        .en_i      (w_timer_en),
        .expired_o (w_expired)
    );

    // ------------------------------------------------------------------
    // Next state. mem_ready wins over an expiring watchdog in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        w_abort   = 1'b0;
        w_retire  = 1'b0;
        w_illegal = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i)    state_d = S_DECODE;
                else if (w_expired) w_abort = 1'b1;
            end
            S_DECODE: begin
                case (op_i)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready_i)    state_d = S_MEMWB;
                else if (w_expired) w_abort = 1'b1;
            end
            S_MEMWB: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_MEMWR: begin
                if (mem_ready_i) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_expired) begin
                    w_abort = 1'b1;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
        if (w_abort) begin
            state_d = S_FETCH;
        end
    end

    // ------------------------------------------------------------------
    // State register and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_done_q  <= 1'b0;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q      <= state_d;
            instr_done_q <= w_retire;
            illegal_op_q <= w_illegal;
            if (w_abort) begin
                mem_timeout_q <= 1'b1;
            end
            if (w_retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode. Only the fetch-side IR/PC loads look at
    // mem_ready, so the IR captures the word in the cycle it arrives.
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_RT;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                w_pc_write  = mem_ready_i;
            end
            S_DECODE: alu_src_b_o = SRCB_IMMSH2;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_o = 1'b1;
                reg_write_o  = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst_o   = 1'b1;
                reg_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                w_pc_write_cond = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                pc_source_o = PCSRC_JUMP;
            end
            S_ADDIWB: reg_write_o = 1'b1;
            default: ;
        endcase
    end

    assign pc_en_o       = w_pc_write | (w_pc_write_cond & zero_i);
    assign state_o       = state_q;
    assign instr_done_o  = instr_done_q;
    assign illegal_op_o  = illegal_op_q;
    assign mem_timeout_o = mem_timeout_q;
    assign instr_count_o = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Self-checking bench for mc_control. Random opcodes, memory
//                latency and zero flag; expected behaviour comes from an
//                instruction-level model that expands each opcode into its
//                list of phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_control;

    localparam int unsigned WAIT_LIMIT = 15;
    localparam int unsigned CNT_W      = 32;

    logic             clk;
    logic             rst;
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic             pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [3:0]       state;
    logic             instr_done, illegal_op, mem_timeout;
    logic [CNT_W-1:0] instr_count;

    mc_control #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_i          (op),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .pc_en_o       (pc_en),
        .i_or_d_o      (i_or_d),
        .mem_read_o    (mem_read),
        .mem_write_o   (mem_write),
        .ir_write_o    (ir_write),
        .reg_dst_o     (reg_dst),
        .mem_to_reg_o  (mem_to_reg),
        .reg_write_o   (reg_write),
        .alu_src_a_o   (alu_src_a),
        .alu_src_b_o   (alu_src_b),
        .alu_op_o      (alu_op),
        .pc_source_o   (pc_source),
        .state_o       (state),
        .instr_done_o  (instr_done),
        .illegal_op_o  (illegal_op),
        .mem_timeout_o (mem_timeout),
        .instr_count_o (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction-level. Decode expands the opcode into the
    // remaining phase list; memory phases stall on mem_ready under a watchdog.
    // ------------------------------------------------------------------
    int               m_state;
    int               m_wait;
    int               m_path[$];
    bit               m_done, m_ill, m_to;
    logic [CNT_W-1:0] m_count;

    function automatic void route(input logic [5:0] o, ref int p[$]);
        p.delete();
        case (o)
            6'b000000: p = '{7, 8};
            6'b100011: p = '{3, 4, 5};
            6'b101011: p = '{3, 6};
            6'b000100: p = '{9};
            6'b000010: p = '{10};
            6'b001000: p = '{11, 12};
            default:   ;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_path.delete();
        m_done  = 0;
        m_ill   = 0;
        m_to    = 0;
        m_count = '0;
    endtask

    // Advance the model across the coming rising edge, using held inputs
    task automatic model_step();
        int nxt;
        bit is_mem;
        is_mem = (m_state == 1) || (m_state == 4) || (m_state == 6);
        m_done = 0;
        m_ill  = 0;
        if (is_mem && !mem_ready) begin
            if (m_wait == int'(WAIT_LIMIT)) begin
                m_to = 1;
                m_path.delete();
                nxt    = 1;
                m_wait = 0;
            end else begin
                m_wait++;
                nxt = m_state;
            end
        end else begin
            if (m_state == 0) begin
                nxt = 1;
            end else if (m_state == 1) begin
                nxt = 2;
            end else if (m_state == 2) begin
                route(op, m_path);
                if (m_path.size() == 0) begin
                    m_ill = 1;
                    nxt   = 1;
                end else begin
                    nxt = m_path.pop_front();
                end
            end else if (m_path.size() > 0) begin
                nxt = m_path.pop_front();
            end else begin
                nxt     = 1;
                m_done  = 1;
                m_count = m_count + 1;
            end
            m_wait = 0;
        end
        m_state = nxt;
    endtask

    // Expected selects: {pc_en,i_or_d,mem_read,mem_write,ir_write,reg_dst,
    //                    mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_source}
    function automatic logic [14:0] exp_ctrl(input int s, input logic rdy, input logic z);
        logic pe, iod, mr, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ao, ps;
        {pe, iod, mr, mw, irw, rd, m2r, rw, sa} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            1:  begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; iod = 1; end
            5:  begin m2r = 1; rw = 1; end
            6:  begin mw = 1; iod = 1; end
            7:  begin sa = 1; ao = 2'b10; end
            8:  begin rd = 1; rw = 1; end
            9:  begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
            10: begin pe = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            default: ;
        endcase
        return {pe, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic [14:0] dut_ctrl();
        return {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'b000000;
            1: return 6'b100011;
            2: return 6'b101011;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            6: return 6'($urandom);
            default: return 6'b111111;
        endcase
    endfunction

    task automatic check_all();
        check("state", 64'(state), 64'(m_state));
        check("ctrl", 64'(dut_ctrl()), 64'(exp_ctrl(m_state, mem_ready, zero)));
        check("flags", 64'({instr_done, illegal_op, mem_timeout}), 64'({m_done, m_ill, m_to}));
        check("count", 64'(instr_count), 64'(m_count));
    endtask

    // One clock: drive at the falling edge, check, then advance the model.
    // The opcode only changes while fetching, as the IR would.
    task automatic do_cycle(input int ready_pct, input int fixed_op);
        @(negedge clk);
        if (m_state <= 1) op = (fixed_op < 0) ? pick_op() : 6'(fixed_op);
        mem_ready = ($urandom_range(0, 99) < ready_pct);
        zero      = 1'($urandom);
        #1;
        check_all();
        model_step();
    endtask

    task automatic run_until(input int target, input int fixed_op);
        for (int i = 0; i < 40 && m_state != target; i++) do_cycle(100, fixed_op);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("pre_rst_state", 64'(state), 64'(m_state));
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_state", 64'(state), 64'd0);
        check("rst_ctrl", 64'(dut_ctrl()), 64'd0);
        check("rst_flags", 64'({instr_done, illegal_op, mem_timeout}), 64'd0);
        check("rst_count", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        model_reset();
        #1;
        check("reset_state", 64'(state), 64'd0);
        check("reset_ctrl", 64'(dut_ctrl()), 64'd0);
        check("reset_flags", 64'({instr_done, illegal_op, mem_timeout}), 64'd0);
        check("reset_count", 64'(instr_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // R-type with memory always ready
        repeat (6) do_cycle(100, 6'b000000);
        // lw with three stalled cycles in MEMRD
        run_until(4, 6'b100011);
        repeat (3) do_cycle(0, 6'b100011);
        repeat (4) do_cycle(100, 6'b100011);
        // branches, zero flag random
        repeat (12) do_cycle(100, 6'b000100);
        // sw watchdog abort after sixteen stalled cycles
        run_until(6, 6'b101011);
        repeat (16) do_cycle(0, 6'b101011);
        repeat (4) do_cycle(100, 6'b101011);
        // ready arriving exactly at the limit wins
        run_until(6, 6'b101011);
        repeat (15) do_cycle(0, 6'b101011);
        repeat (3) do_cycle(100, 6'b101011);
        // fetch abort and retry
        run_until(1, 6'b000000);
        repeat (20) do_cycle(0, 6'b000000);
        repeat (6) do_cycle(100, 6'b000000);
        // illegal opcode
        repeat (6) do_cycle(100, 6'b111111);
        // reset while a store waits on memory
        run_until(6, 6'b101011);
        repeat (3) do_cycle(0, 6'b101011);
        do_reset();
        repeat (8) do_cycle(100, 6'b001000);

        // random traffic with varying memory latency and occasional reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else do_cycle((i < 1500) ? 80 : (i < 2500) ? 40 : 4, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
